// File: rtl/lsu_mc.sv
// Multicycle RV32I load/store unit: one request at a time, word-aligned bus access with strobes.
// Loads are lane-selected and extended; misaligned, illegal, timeout and bus errors are reported.
module lsu_mc #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic [1:0]        rsp_err,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_wstrb,
  output logic [31:0]       mem_wdata,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_err
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CNT_W-1:0] TO_MAX  = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_R, RESP} state_t;

  state_t            state, state_nxt;
  logic              wr_q;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [CNT_W-1:0]  cnt;
  logic [31:0]       rdata_q, rdata_nxt;
  logic [1:0]        err_q, err_nxt;
  logic              illegal, misal, timed_out;
  logic [31:0]       lane, ext;
  logic [3:0]        strb;
  logic [31:0]       wrep;

  always_comb begin
    if (req_write) illegal = (req_funct3 >= 3'd3);
    else           illegal = (req_funct3 == 3'd3) || (req_funct3 >= 3'd6);
    misal = ((req_funct3[1:0] == 2'd1) && req_addr[0]) ||
            ((req_funct3[1:0] == 2'd2) && (req_addr[1:0] != 2'b00));
  end

  // Saturating counter; a load handshake on the last REQ cycle still times out in WAIT_R.
  assign timed_out = (TIMEOUT != 0) && (cnt >= TO_LAST);

  always_comb begin
    lane = mem_rdata >> {addr_q[1:0], 3'b000};
    ext  = lane;
    case (f3_q)
      3'd0:    ext = {{24{lane[7]}}, lane[7:0]};
      3'd1:    ext = {{16{lane[15]}}, lane[15:0]};
      3'd4:    ext = {24'd0, lane[7:0]};
      3'd5:    ext = {16'd0, lane[15:0]};
      default: ext = lane;
    endcase
  end

  always_comb begin
    strb = 4'b1111;
    wrep = wdata_q;
    case (f3_q[1:0])
      2'd0: begin
        strb = 4'b0001 << addr_q[1:0];
        wrep = {4{wdata_q[7:0]}};
      end
      2'd1: begin
        strb = 4'b0011 << addr_q[1:0];
        wrep = {2{wdata_q[15:0]}};
      end
      default: begin
        strb = 4'b1111;
        wrep = wdata_q;
      end
    endcase
  end

  always_comb begin
    state_nxt = state;
    rdata_nxt = rdata_q;
    err_nxt   = err_q;
    case (state)
      IDLE: if (req_valid) begin
        if (illegal) begin
          state_nxt = RESP; err_nxt = 2'd3; rdata_nxt = 32'd0;
        end else if (misal) begin
          state_nxt = RESP; err_nxt = 2'd1; rdata_nxt = 32'd0;
        end else begin
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (mem_ready) begin
          if (wr_q) begin
            state_nxt = RESP; err_nxt = mem_err ? 2'd3 : 2'd0; rdata_nxt = 32'd0;
          end else begin
            state_nxt = WAIT_R;
          end
        end else if (timed_out) begin
          state_nxt = RESP; err_nxt = 2'd2; rdata_nxt = 32'd0;
        end
      end
      WAIT_R: begin
        if (mem_rvalid) begin
          state_nxt = RESP;
          err_nxt   = mem_err ? 2'd3 : 2'd0;
          rdata_nxt = mem_err ? 32'd0 : ext;
        end else if (timed_out) begin
          state_nxt = RESP; err_nxt = 2'd2; rdata_nxt = 32'd0;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      wr_q    <= 1'b0;
      f3_q    <= 3'd0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      cnt     <= '0;
      rdata_q <= 32'd0;
      err_q   <= 2'd0;
    end else begin
      state   <= state_nxt;
      rdata_q <= rdata_nxt;
      err_q   <= err_nxt;
      if (state == IDLE && req_valid) begin
        wr_q    <= req_write;
        f3_q    <= req_funct3;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        cnt     <= '0;
      end else if ((state == REQ || state == WAIT_R) && cnt != TO_MAX) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign req_ready = (state == IDLE) && !rst;
  assign rsp_valid = (state == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign mem_valid = (state == REQ);
  assign mem_write = (state == REQ) && wr_q;
  assign mem_addr  = (state == REQ) ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign mem_wstrb = (state == REQ && wr_q) ? strb : 4'd0;
  assign mem_wdata = (state == REQ && wr_q) ? wrep : 32'd0;

endmodule

// File: tb/tb_lsu_mc.sv
// Directed bench for lsu_mc with TIMEOUT=8.
module tb_lsu_mc;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_err;
  logic        mem_valid, mem_ready, mem_write;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_rvalid, mem_err;
  logic [31:0] mem_rdata;

  int checks = 0;
  int failures = 0;
  int lat, mv_cnt;
  logic [31:0] s_addr, s_wdata, r_rdata;
  logic [3:0]  s_wstrb;
  logic        s_write, rv_seen;
  logic [1:0]  r_err;

  lsu_mc #(.ADDR_W(32), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (mem_valid) mv_cnt++;
  endtask

  task automatic do_req(input logic w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    int n;
    n = 0;
    while (!req_ready && n < 20) begin tick(); n++; end
    chk("req_ready_before_req", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = d;
    mv_cnt = 0;
    tick();
    req_valid = 1'b0;
    s_addr = mem_addr; s_wdata = mem_wdata; s_wstrb = mem_wstrb; s_write = mem_write;
    lat = 1;
    while (!rsp_valid && lat < 40) begin tick(); lat++; end
    r_rdata = rsp_rdata; r_err = rsp_err;
    chk("rsp_valid_seen", {31'd0, rsp_valid}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0; mem_ready = 1'b1; mem_rvalid = 1'b1;
    mem_rdata = 32'd0; mem_err = 1'b0;
    #2;
    chk("reset_req_ready", {31'd0, req_ready}, 32'd0);
    chk("reset_mem_valid", {31'd0, mem_valid}, 32'd0);
    chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("post_reset_req_ready", {31'd0, req_ready}, 32'd1);

    // 1: SB to byte 3
    do_req(1'b1, 3'd0, 32'h0000_1003, 32'h0000_00A5);
    chk("sb_mem_addr", s_addr, 32'h0000_1000);
    chk("sb_wstrb", {28'd0, s_wstrb}, 32'h8);
    chk("sb_wdata", s_wdata, 32'hA5A5_A5A5);
    chk("sb_write", {31'd0, s_write}, 32'd1);
    chk("sb_latency", lat, 32'd2);
    chk("sb_err", {30'd0, r_err}, 32'd0);
    chk("sb_mv_cycles", mv_cnt, 32'd1);
    chk("no_accept_in_resp", {31'd0, req_ready}, 32'd0);

    // SH to upper half
    do_req(1'b1, 3'd1, 32'h0000_1002, 32'h1234_BEEF);
    chk("sh_wstrb", {28'd0, s_wstrb}, 32'hC);
    chk("sh_wdata", s_wdata, 32'hBEEF_BEEF);

    // 2: byte/half loads from lane 2
    mem_rdata = 32'h12F0_3456;
    do_req(1'b0, 3'd0, 32'h0000_2002, 32'd0);
    chk("lb_rdata", r_rdata, 32'hFFFF_FFF0);
    chk("lb_latency", lat, 32'd3);
    chk("lb_wstrb", {28'd0, s_wstrb}, 32'h0);
    chk("lb_mem_addr", s_addr, 32'h0000_2000);
    do_req(1'b0, 3'd4, 32'h0000_2002, 32'd0);
    chk("lbu_rdata", r_rdata, 32'h0000_00F0);
    chk("lbu_latency", lat, 32'd3);
    do_req(1'b0, 3'd1, 32'h0000_2002, 32'd0);
    chk("lh_rdata", r_rdata, 32'h0000_12F0);
    chk("lh_latency", lat, 32'd3);

    // 3: misaligned
    do_req(1'b0, 3'd2, 32'h0000_3001, 32'd0);
    chk("lw_mis_err", {30'd0, r_err}, 32'd1);
    chk("lw_mis_latency", lat, 32'd1);
    chk("lw_mis_no_bus", mv_cnt, 32'd0);
    do_req(1'b1, 3'd1, 32'h0000_3003, 32'hFFFF_FFFF);
    chk("sh_mis_err", {30'd0, r_err}, 32'd1);
    chk("sh_mis_latency", lat, 32'd1);
    chk("sh_mis_no_bus", mv_cnt, 32'd0);

    // 5: bus error on load, illegal funct3
    mem_err = 1'b1; mem_rdata = 32'h1111_1111;
    do_req(1'b0, 3'd2, 32'h0000_6000, 32'd0);
    chk("lw_buserr_err", {30'd0, r_err}, 32'd3);
    chk("lw_buserr_rdata", r_rdata, 32'd0);
    mem_err = 1'b0;
    do_req(1'b0, 3'd3, 32'h0000_6000, 32'd0);
    chk("illegal_err", {30'd0, r_err}, 32'd3);
    chk("illegal_latency", lat, 32'd1);
    chk("illegal_no_bus", mv_cnt, 32'd0);

    // 4: timeout with mem_ready low
    mem_ready = 1'b0;
    do_req(1'b0, 3'd2, 32'h0000_4000, 32'd0);
    chk("to_mv_cycles", mv_cnt, 32'd8);
    chk("to_latency", lat, 32'd9);
    chk("to_err", {30'd0, r_err}, 32'd2);
    chk("to_rdata", r_rdata, 32'd0);
    mem_ready = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    do_req(1'b0, 3'd2, 32'h0000_4000, 32'd0);
    chk("after_to_rdata", r_rdata, 32'hDEAD_BEEF);
    chk("after_to_err", {30'd0, r_err}, 32'd0);

    // 6: reset during WAIT_R
    mem_rvalid = 1'b0;
    tick();
    req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'd2; req_addr = 32'h0000_5000;
    tick();
    req_valid = 1'b0;
    tick();
    chk("wait_r_mem_valid", {31'd0, mem_valid}, 32'd0);
    rst = 1'b1;
    #1;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", {30'd0, rsp_err}, 32'd0);
    chk("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
    rv_seen = rsp_valid;
    for (int i = 0; i < 3; i++) begin tick(); rv_seen = rv_seen | rsp_valid; end
    chk("rst_no_rsp", {31'd0, rv_seen}, 32'd0);
    rst = 1'b0;
    #1;
    chk("rel_req_ready", {31'd0, req_ready}, 32'd1);
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
    do_req(1'b0, 3'd2, 32'h0000_5004, 32'd0);
    chk("fresh_lw_rdata", r_rdata, 32'hCAFE_F00D);
    chk("fresh_lw_latency", lat, 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/lsu_mc.md
Name: lsu_mc

Overview:
- Parametrised multicycle load/store unit; successor to the core's fixed single-cycle memory access path. It sits between the core controller and a variable-latency memory port.
- Accepts one RV32I load/store request at a time and generates word-aligned bus transactions with byte strobes. It extracts and extends load data, and reports misaligned, timeout and bus errors.
- The controller stalls on req_ready/rsp_valid instead of assuming fixed memory latency.

Parameters:
ADDR_W, 32, address width in bits (>=3); data path fixed at 32 bits
TIMEOUT, 64, max cycles spent in REQ+WAIT_R before aborting; 0 disables timeout
CNT_W, $clog2(TIMEOUT+1), timeout counter width (derived, not overridden)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  unit can accept request
req_write  in  1  1=store, 0=load
req_funct3  in  3  RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
req_addr  in  ADDR_W  byte address
req_wdata  in  32  store data (rs2)
rsp_valid  out  1  one-cycle completion pulse
rsp_rdata  out  32  extended load data; 0 for stores/errors
rsp_err  out  2  0=OK, 1=MISALIGNED, 2=TIMEOUT, 3=BUS/ILLEGAL
mem_valid  out  1  bus request
mem_ready  in  1  bus accepts request
mem_write  out  1  bus write
mem_addr  out  ADDR_W  word address {req_addr[ADDR_W-1:2],2'b00}
mem_wstrb  out  4  byte strobes
mem_wdata  out  32  lane-replicated store data
mem_rvalid  in  1  read data valid
mem_rdata  in  32  read data
mem_err  in  1  bus error, qualified by mem_ready (write) or mem_rvalid (read)

Behaviour:
- Reset (async, any state): state=IDLE; all outputs 0 except req_ready. req_ready=0 while rst is high and 1 in IDLE afterwards. Timeout counter=0. An in-flight transaction is abandoned with no response.
- FSM states: IDLE, REQ, WAIT_R, RESP. req_ready=1 only in IDLE.
- IDLE: on req_valid, latch write/funct3/addr/wdata.
  - Illegal funct3 (load 3,6,7; store >=3) -> RESP with err=3.
  - Misaligned (H with addr[0]=1; W with addr[1:0]!=0) -> RESP with err=1. No bus transaction is issued for either case.
  - Otherwise -> REQ.
- REQ: mem_valid=1; mem_addr/mem_write/mem_wstrb/mem_wdata stable until handshake.
  - On mem_valid&&mem_ready: store -> RESP (err=3 if mem_err, else 0); load -> WAIT_R.
- WAIT_R: mem_valid=0. On mem_rvalid -> RESP.
  - mem_err=1: err=3, rdata=0.
  - Otherwise: lane select by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW pass-through.
- Timeout: counter clears on IDLE->REQ and increments each cycle in REQ/WAIT_R. When it reaches TIMEOUT with no completing event: -> RESP, err=2, mem_valid drops. A completing event in the same cycle wins over timeout.
- RESP: rsp_valid=1 for exactly one cycle, then IDLE. rsp_rdata/rsp_err are registered and hold until the next RESP.
- Strobes: B -> 4'b0001<<addr[1:0], wdata={4{wdata[7:0]}}; H -> 4'b0011<<addr[1:0], wdata={2{wdata[15:0]}}; W -> 4'b1111, wdata unchanged. Loads drive wstrb=0.
- Latency (mem_ready already high, mem_rvalid the cycle after handshake): store 2 cycles from acceptance to rsp_valid; load 3 cycles; misaligned/illegal 1 cycle.
- Back-to-back: a new request is accepted the cycle after RESP; there is no acceptance during RESP.
- mem_rvalid outside WAIT_R is ignored.

Test Plan:
1. SB addr=0x1003 wdata=0x000000A5, mem_ready=1 -> mem_addr=0x1000, wstrb=4'b1000, wdata=0xA5A5A5A5; rsp_valid 2 cycles after accept, err=0.
2. LB addr=0x2002, mem_rdata=0x12F03456 -> rsp_rdata=0xFFFFFFF0; LBU same -> 0x000000F0; LH addr=0x2002 -> 0x000012F0; each 3 cycles to rsp_valid.
3. LW addr=0x3001 and SH addr=0x3003 -> rsp_valid the next cycle, err=1; mem_valid never asserted.
4. TIMEOUT=8, LW with mem_ready low -> mem_valid high 8 cycles then low; rsp_err=2, rsp_rdata=0; the next request is accepted.
5. LW with mem_rvalid&&mem_err -> err=3, rdata=0. Separately, a load with funct3=3 -> err=3 immediately with no bus request.
6. Assert rst during WAIT_R -> all outputs 0 immediately with no rsp_valid. After release, req_ready=1 and a fresh LW returns correct data.
